// File: rtl/cp0_exception_reg_if.sv
// Bus bundle between the pipeline and the CP0 register file: MTC0/MFC0
// access, exception/ERET commit from MEM, interrupt lines and register taps.
interface cp0_exception_reg_if #(
  parameter int HW_INT_COUNT = 6
);
  logic                    write_enable_input;
  logic [4:0]              write_address_input;
  logic [4:0]              read_address_input;
  logic [31:0]             data_input;
  logic [HW_INT_COUNT-1:0] interrupt_input;
  logic                    exception_valid_input;
  logic [4:0]              exception_code_input;
  logic [31:0]             exception_pc_input;
  logic                    in_delay_slot_input;
  logic [31:0]             bad_address_input;
  logic                    eret_input;
  logic [31:0]             data_output;
  logic [31:0]             count_output;
  logic [31:0]             compare_output;
  logic [31:0]             status_output;
  logic [31:0]             cause_output;
  logic [31:0]             epc_output;
  logic [31:0]             badvaddr_output;
  logic [31:0]             config_output;
  logic [31:0]             prid_output;
  logic                    timer_interrupt_output;
  logic                    interrupt_pending_output;

  // Pipeline side: drives accesses and commits, observes CP0 state
  modport master (
    output write_enable_input, write_address_input, read_address_input,
           data_input, interrupt_input, exception_valid_input,
           exception_code_input, exception_pc_input, in_delay_slot_input,
           bad_address_input, eret_input,
    input  data_output, count_output, compare_output, status_output,
           cause_output, epc_output, badvaddr_output, config_output,
           prid_output, timer_interrupt_output, interrupt_pending_output
  );

  // CP0 side
  modport slave (
    input  write_enable_input, write_address_input, read_address_input,
           data_input, interrupt_input, exception_valid_input,
           exception_code_input, exception_pc_input, in_delay_slot_input,
           bad_address_input, eret_input,
    output data_output, count_output, compare_output, status_output,
           cause_output, epc_output, badvaddr_output, config_output,
           prid_output, timer_interrupt_output, interrupt_pending_output
  );
endinterface

// File: rtl/cp0_exception_reg.sv
// CP0 register file for the pipelined MIPS core: prescaled Count/Compare
// timer with sticky interrupt, Status/Cause/EPC/BadVAddr with exception and
// ERET commit, combinational MFC0 read with write-back bypass.
module cp0_exception_reg #(
  parameter int          HW_INT_COUNT  = 6,
  parameter int          COUNT_DIVIDER = 1,
  parameter int          TIMER_LINE    = 5,
  parameter logic [31:0] PRID_VALUE    = 32'h004C0102
) (
  input logic               clock,
  input logic               reset,
  cp0_exception_reg_if.slave bus
);

  localparam logic [4:0] REG_BADVADDR = 5'd8;
  localparam logic [4:0] REG_COUNT    = 5'd9;
  localparam logic [4:0] REG_COMPARE  = 5'd11;
  localparam logic [4:0] REG_STATUS   = 5'd12;
  localparam logic [4:0] REG_CAUSE    = 5'd13;
  localparam logic [4:0] REG_EPC      = 5'd14;
  localparam logic [4:0] REG_PRID     = 5'd15;
  localparam logic [4:0] REG_CONFIG   = 5'd16;

  localparam logic [31:0] STATUS_RESET = 32'h10000000;
  localparam logic [31:0] CONFIG_VALUE = 32'h00008000;
  // Software may only touch the two soft-interrupt bits and bits 23:22
  localparam logic [31:0] CAUSE_WRITE_MASK = 32'h00C00300;

  localparam int PRESCALE_WIDTH = (COUNT_DIVIDER > 1) ? $clog2(COUNT_DIVIDER) : 1;
  localparam logic [PRESCALE_WIDTH-1:0] PRESCALE_LAST = PRESCALE_WIDTH'(COUNT_DIVIDER - 1);

  logic [PRESCALE_WIDTH-1:0] prescaler;
  logic [31:0] count;
  logic [31:0] compare;
  logic [31:0] status;
  logic [31:0] cause;
  logic [31:0] epc;
  logic [31:0] badvaddr;
  logic        timer;

  logic        exc;
  logic        exl;
  logic        write_count;
  logic        write_compare;
  logic        write_status;
  logic        write_cause;
  logic        write_epc;
  logic        read_hit;
  logic        tick;
  logic [5:0]  ip_next;
  logic [31:0] cause_written;
  logic [31:0] cause_next;
  logic [31:0] status_next;
  logic [31:0] epc_next;
  logic [31:0] badvaddr_next;

  assign exc           = bus.exception_valid_input;
  assign exl           = status[1];
  assign write_count   = bus.write_enable_input && (bus.write_address_input == REG_COUNT);
  assign write_compare = bus.write_enable_input && (bus.write_address_input == REG_COMPARE);
  assign write_status  = bus.write_enable_input && (bus.write_address_input == REG_STATUS);
  assign write_cause   = bus.write_enable_input && (bus.write_address_input == REG_CAUSE);
  assign write_epc     = bus.write_enable_input && (bus.write_address_input == REG_EPC);
  assign read_hit      = bus.write_enable_input && (bus.write_address_input == bus.read_address_input);
  assign tick          = (prescaler == PRESCALE_LAST);
  assign cause_written = (cause & ~CAUSE_WRITE_MASK) | (bus.data_input & CAUSE_WRITE_MASK);

  // Hardware IP bits follow the lines every cycle; the timer is folded into its line
  always_comb begin
    ip_next = '0;
    ip_next[HW_INT_COUNT-1:0] = bus.interrupt_input;
    ip_next[TIMER_LINE] = ip_next[TIMER_LINE] | timer;
  end

  // Next-state for the exception-visible registers; a committing exception
  // overrides any software write to them in the same cycle
  always_comb begin
    cause_next = write_cause && !exc ? cause_written : cause;
    cause_next[15:10] = ip_next;
    cause_next[30] = timer;
    if (exc) begin
      if (!exl) begin
        cause_next[31] = bus.in_delay_slot_input;
      end
      cause_next[6:2] = bus.exception_code_input;
    end

    status_next = write_status ? bus.data_input : status;
    if (bus.eret_input) begin
      status_next[1] = 1'b0;
    end
    if (exc) begin
      status_next = status | 32'h00000002;
    end

    epc_next = write_epc ? bus.data_input : epc;
    if (exc) begin
      if (exl) begin
        epc_next = epc;
      end else if (bus.in_delay_slot_input) begin
        epc_next = bus.exception_pc_input - 32'd4;
      end else begin
        epc_next = bus.exception_pc_input;
      end
    end

    badvaddr_next = badvaddr;
    if (exc && (bus.exception_code_input == 5'd4 || bus.exception_code_input == 5'd5)) begin
      badvaddr_next = bus.bad_address_input;
    end
  end

  // Register update: prescaled Count, sticky Compare match, exception state
  always_ff @(posedge clock) begin
    if (reset) begin
      prescaler <= '0;
      count     <= '0;
      compare   <= '0;
      status    <= STATUS_RESET;
      cause     <= '0;
      epc       <= '0;
      badvaddr  <= '0;
      timer     <= 1'b0;
    end else begin
      if (write_count) begin
        count     <= bus.data_input;
        prescaler <= '0;
      end else if (tick) begin
        count     <= count + 32'd1;
        prescaler <= '0;
      end else begin
        prescaler <= prescaler + 1'b1;
      end

      if (write_compare) begin
        compare <= bus.data_input;
        timer   <= 1'b0;
      end else if (compare != 32'd0 && count == compare) begin
        timer <= 1'b1;
      end

      status   <= status_next;
      cause    <= cause_next;
      epc      <= epc_next;
      badvaddr <= badvaddr_next;
    end
  end

  // MFC0 read, returning the value being written back this cycle when it aliases
  always_comb begin
    bus.data_output = '0;
    if (!reset) begin
      case (bus.read_address_input)
        REG_COUNT:    bus.data_output = read_hit ? bus.data_input : count;
        REG_COMPARE:  bus.data_output = read_hit ? bus.data_input : compare;
        REG_STATUS:   bus.data_output = (read_hit && !exc) ? bus.data_input : status;
        REG_CAUSE:    bus.data_output = (read_hit && !exc) ? cause_written : cause;
        REG_EPC:      bus.data_output = (read_hit && !exc) ? bus.data_input : epc;
        REG_BADVADDR: bus.data_output = badvaddr;
        REG_PRID:     bus.data_output = PRID_VALUE;
        REG_CONFIG:   bus.data_output = CONFIG_VALUE;
        default:      bus.data_output = '0;
      endcase
    end
  end

  assign bus.count_output             = count;
  assign bus.compare_output           = compare;
  assign bus.status_output            = status;
  assign bus.cause_output             = cause;
  assign bus.epc_output               = epc;
  assign bus.badvaddr_output          = badvaddr;
  assign bus.config_output            = CONFIG_VALUE;
  assign bus.prid_output              = PRID_VALUE;
  assign bus.timer_interrupt_output   = timer;
  assign bus.interrupt_pending_output = status[0] & ~status[1] & (|(cause[15:8] & status[15:8]));

endmodule
